// File: rtl/instruction_dispatcher_if.sv
// Push and dispatch handshake bundle for the instruction dispatcher.
// The slave modport is the dispatcher side; the master drives instructions in.
interface instruction_dispatcher_if #(
    parameter int OPCODE_WIDTH               = 8,
    parameter int FLAG_WIDTH                 = 8,
    parameter int LENGTH_WIDTH               = 8,
    parameter int HOST_MEMORY_ADDRESS_WIDTH  = 64,
    parameter int LOCAL_MEMORY_ADDRESS_WIDTH = 24
);
    localparam int IW = OPCODE_WIDTH + FLAG_WIDTH + LENGTH_WIDTH
                      + HOST_MEMORY_ADDRESS_WIDTH
                      + LOCAL_MEMORY_ADDRESS_WIDTH;

    logic                                  in_valid;
    logic                                  in_ready;
    logic [IW-1:0]                         in_instruction;
    logic [3:0]                            out_valid;
    logic [3:0]                            out_ready;
    logic [OPCODE_WIDTH-1:0]               out_opcode;
    logic [FLAG_WIDTH-1:0]                 out_flags;
    logic [LENGTH_WIDTH-1:0]               out_length;
    logic [HOST_MEMORY_ADDRESS_WIDTH-1:0]  out_host_addr;
    logic [LOCAL_MEMORY_ADDRESS_WIDTH-1:0] out_local_addr;

    modport slave (
        input  in_valid, in_instruction, out_ready,
        output in_ready, out_valid, out_opcode, out_flags,
        output out_length, out_host_addr, out_local_addr
    );

    modport master (
        output in_valid, in_instruction, out_ready,
        input  in_ready, out_valid, out_opcode, out_flags,
        input  out_length, out_host_addr, out_local_addr
    );
endinterface

// File: rtl/instruction_dispatcher.sv
// Instruction queue with opcode decode and per-unit dispatch handshakes.
// SYNC waits for all units idle; HALT parks until resume.
module instruction_dispatcher #(
    parameter int OPCODE_WIDTH               = 8,
    parameter int FLAG_WIDTH                 = 8,
    parameter int LENGTH_WIDTH               = 8,
    parameter int HOST_MEMORY_ADDRESS_WIDTH  = 64,
    parameter int LOCAL_MEMORY_ADDRESS_WIDTH = 24,
    parameter int QUEUE_DEPTH                = 4,
    localparam int INSTRUCTION_WIDTH = OPCODE_WIDTH + FLAG_WIDTH
                                     + LENGTH_WIDTH
                                     + HOST_MEMORY_ADDRESS_WIDTH
                                     + LOCAL_MEMORY_ADDRESS_WIDTH,
    localparam int COUNT_WIDTH = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    instruction_dispatcher_if.slave bus,
    input  logic [3:0]             unit_busy,
    input  logic                   resume,
    input  logic                   illegal_clear,
    output logic                   halted,
    output logic                   illegal_opcode,
    output logic [COUNT_WIDTH-1:0] queue_count
);
    localparam int PW  = $clog2(QUEUE_DEPTH);
    localparam int LA  = LOCAL_MEMORY_ADDRESS_WIDTH;
    localparam int HA  = HOST_MEMORY_ADDRESS_WIDTH;
    localparam int LN  = LENGTH_WIDTH;
    localparam int FL  = FLAG_WIDTH;
    localparam int IW  = INSTRUCTION_WIDTH;
    localparam int OW  = OPCODE_WIDTH;

    typedef enum logic [1:0] {
        S_RUN,
        S_SYNC,
        S_HALT
    } state_e;

    state_e                 state_q, state_d;
    logic [IW-1:0]          mem_q [QUEUE_DEPTH];
    logic [PW-1:0]          wp_q, wp_d, rp_q, rp_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   ill_q, ill_d;

    logic          empty, push, pop, ill_set;
    logic [IW-1:0] head;
    logic [OW-1:0] head_op;
    logic [3:0]    unit, valid_d;
    logic op_nop, op_mem, op_wgt, op_mxu, op_act;
    logic op_sync, op_halt, op_ill;

    assign empty       = (count_q == '0);
    assign bus.in_ready = (count_q != COUNT_WIDTH'(QUEUE_DEPTH));
    assign push        = bus.in_valid && bus.in_ready;
    assign head        = empty ? '0 : mem_q[rp_q];
    assign head_op     = head[IW-1 -: OW];

    assign bus.out_opcode     = head_op;
    assign bus.out_flags      = head[LA+HA+LN +: FL];
    assign bus.out_length     = head[LA+HA +: LN];
    assign bus.out_host_addr  = head[LA +: HA];
    assign bus.out_local_addr = head[0 +: LA];
    assign bus.out_valid      = valid_d;

    assign op_nop  = (head_op == OW'(0));
    assign op_mem  = (head_op == OW'(1)) || (head_op == OW'(2));
    assign op_wgt  = (head_op == OW'(3));
    assign op_mxu  = (head_op == OW'(4));
    assign op_act  = (head_op == OW'(5));
    assign op_sync = (head_op == OW'(6));
    assign op_halt = (head_op == OW'(7));
    assign op_ill  = !(op_nop || op_mem || op_wgt || op_mxu
                       || op_act || op_sync || op_halt);

    always_comb begin
        unit = 4'b0000;
        unique case (1'b1)
            op_mem:  unit = 4'b0001;
            op_wgt:  unit = 4'b0010;
            op_mxu:  unit = 4'b0100;
            op_act:  unit = 4'b1000;
            default: unit = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RUN: begin
                if (!empty && op_sync) state_d = S_SYNC;
                else if (!empty && op_halt) state_d = S_HALT;
            end
            S_SYNC: if (unit_busy == 4'b0000) state_d = S_RUN;
            S_HALT: if (resume) state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    // Non-dispatching opcodes (NOP/SYNC/HALT/illegal) retire in one cycle.
    always_comb begin
        valid_d = 4'b0000;
        pop     = 1'b0;
        ill_set = 1'b0;
        halted  = (state_q == S_HALT);
        if (state_q == S_RUN && !empty) begin
            if (|unit) begin
                valid_d = unit;
                pop     = |(unit & bus.out_ready);
            end else begin
                pop     = 1'b1;
                ill_set = op_ill;
            end
        end
    end

    always_comb begin
        wp_d    = push ? wp_q + PW'(1) : wp_q;
        rp_d    = pop ? rp_q + PW'(1) : rp_q;
        count_d = count_q + COUNT_WIDTH'(push) - COUNT_WIDTH'(pop);
        ill_d   = ill_set || (ill_q && !illegal_clear);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ill_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ill_q   <= ill_d;
        end
    end

    // Storage needs no reset: an empty queue masks the head to zero.
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= bus.in_instruction;
    end

    assign queue_count    = count_q;
    assign illegal_opcode = ill_q;
endmodule

// File: tb/tb_instruction_dispatcher.sv
// Directed bench for instruction_dispatcher at default parameters.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_instruction_dispatcher;
    logic       clk;
    logic       rst_n;
    logic [3:0] unit_busy;
    logic       resume;
    logic       illegal_clear;
    logic       halted;
    logic       illegal_opcode;
    logic [2:0] queue_count;
    int         tests;
    int         failed;

    instruction_dispatcher_if bus ();

    instruction_dispatcher dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus.slave),
        .unit_busy      (unit_busy),
        .resume         (resume),
        .illegal_clear  (illegal_clear),
        .halted         (halted),
        .illegal_opcode (illegal_opcode),
        .queue_count    (queue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [111:0] mk(
        input logic [7:0]  op,
        input logic [7:0]  fl,
        input logic [7:0]  ln,
        input logic [63:0] ha,
        input logic [23:0] la
    );
        return {op, fl, ln, ha, la};
    endfunction

    task automatic chk(
        input string        tag,
        input logic [127:0] obs,
        input logic [127:0] exp
    );
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        failed = 0;
        rst_n = 1'b0;
        unit_busy = 4'b0;
        resume = 1'b0;
        illegal_clear = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_instruction = '0;
        bus.out_ready = 4'b0;
        #1;
        chk("rst_count", queue_count, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal_opcode, 0);
        chk("rst_opcode", bus.out_opcode, 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // MATMUL single dispatch
        bus.out_ready = 4'b0100;
        bus.in_valid = 1'b1;
        bus.in_instruction = mk(8'h04, 8'h01, 8'h10, 64'h0, 24'h000100);
        step();
        bus.in_valid = 1'b0;
        chk("mm_valid", bus.out_valid, 4'b0100);
        chk("mm_opcode", bus.out_opcode, 8'h04);
        chk("mm_flags", bus.out_flags, 8'h01);
        chk("mm_length", bus.out_length, 8'h10);
        chk("mm_local", bus.out_local_addr, 24'h000100);
        chk("mm_count1", queue_count, 1);
        step();
        chk("mm_count0", queue_count, 0);
        chk("mm_valid0", bus.out_valid, 0);
        chk("mm_empty_op", bus.out_opcode, 0);

        // Fill, hold the fifth, then drain with wrap
        bus.out_ready = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instruction = mk(8'h01, 8'h0, 8'h0, 64'h0, 24'(i));
            step();
        end
        chk("full_count", queue_count, 4);
        chk("full_ready", bus.in_ready, 0);
        bus.in_instruction = mk(8'h02, 8'h0, 8'h0, 64'hBEEF, 24'h4);
        step();
        chk("held_count", queue_count, 4);
        chk("held_head", bus.out_local_addr, 24'h0);
        chk("held_valid", bus.out_valid, 4'b0001);
        bus.out_ready = 4'b0001;
        step();
        chk("d1_count", queue_count, 3);
        chk("d1_head", bus.out_local_addr, 24'h1);
        chk("d1_ready", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        chk("d2_count", queue_count, 3);
        chk("d2_head", bus.out_local_addr, 24'h2);
        step();
        chk("d3_count", queue_count, 2);
        chk("d3_head", bus.out_local_addr, 24'h3);
        step();
        chk("d4_count", queue_count, 1);
        chk("d4_head", bus.out_local_addr, 24'h4);
        chk("d4_op", bus.out_opcode, 8'h02);
        chk("d4_host", bus.out_host_addr, 64'hBEEF);
        step();
        chk("d5_count", queue_count, 0);

        // SYNC waits for idle units
        bus.out_ready = 4'b0000;
        unit_busy = 4'b0010;
        bus.in_valid = 1'b1;
        bus.in_instruction = mk(8'h06, 8'h0, 8'h0, 64'h0, 24'h0);
        step();
        chk("sy_head_valid", bus.out_valid, 0);
        bus.in_instruction = mk(8'h01, 8'h0, 8'h0, 64'h0, 24'hAB);
        step();
        bus.in_valid = 1'b0;
        chk("sy_count", queue_count, 1);
        chk("sy_wait1", bus.out_valid, 0);
        step();
        chk("sy_wait2", bus.out_valid, 0);
        unit_busy = 4'b0000;
        chk("sy_wait3", bus.out_valid, 0);
        step();
        chk("sy_go", bus.out_valid, 4'b0001);
        chk("sy_local", bus.out_local_addr, 24'hAB);
        bus.out_ready = 4'b0001;
        step();
        chk("sy_count0", queue_count, 0);

        // HALT parks until resume
        bus.out_ready = 4'b1000;
        bus.in_valid = 1'b1;
        bus.in_instruction = mk(8'h07, 8'h0, 8'h0, 64'h0, 24'h0);
        step();
        bus.in_instruction = mk(8'h05, 8'h0, 8'h0, 64'h0, 24'h0);
        step();
        bus.in_valid = 1'b0;
        chk("ht_halted", halted, 1);
        chk("ht_valid", bus.out_valid, 0);
        chk("ht_count", queue_count, 1);
        step();
        chk("ht_still", halted, 1);
        resume = 1'b1;
        step();
        resume = 1'b0;
        chk("ht_resumed", halted, 0);
        chk("ht_go", bus.out_valid, 4'b1000);
        step();
        chk("ht_count0", queue_count, 0);

        // Illegal opcode dropped, sticky flag
        bus.out_ready = 4'b0000;
        bus.in_valid = 1'b1;
        bus.in_instruction = mk(8'h2A, 8'h0, 8'h0, 64'h0, 24'h0);
        step();
        bus.in_instruction = mk(8'h03, 8'h0, 8'h0, 64'h0, 24'h0);
        step();
        bus.in_valid = 1'b0;
        chk("il_flag", illegal_opcode, 1);
        chk("il_valid", bus.out_valid, 4'b0010);
        chk("il_count", queue_count, 1);
        illegal_clear = 1'b1;
        step();
        illegal_clear = 1'b0;
        chk("il_cleared", illegal_opcode, 0);
        bus.out_ready = 4'b0010;
        step();
        chk("il_count0", queue_count, 0);
        bus.in_valid = 1'b1;
        bus.in_instruction = mk(8'h2A, 8'h0, 8'h0, 64'h0, 24'h0);
        step();
        bus.in_valid = 1'b0;
        illegal_clear = 1'b1;
        step();
        illegal_clear = 1'b0;
        chk("il_set_wins", illegal_opcode, 1);
        chk("il_count_e", queue_count, 0);

        // NOP retires silently
        bus.in_valid = 1'b1;
        bus.in_instruction = mk(8'h00, 8'h0, 8'h0, 64'h0, 24'h0);
        step();
        bus.in_valid = 1'b0;
        chk("nop_count", queue_count, 1);
        chk("nop_valid", bus.out_valid, 0);
        step();
        chk("nop_count0", queue_count, 0);

        // Async reset while halted with three queued
        bus.out_ready = 4'b0000;
        bus.in_valid = 1'b1;
        bus.in_instruction = mk(8'h07, 8'h0, 8'h0, 64'h0, 24'h0);
        step();
        bus.in_instruction = mk(8'h01, 8'h0, 8'h0, 64'h0, 24'h7);
        step();
        step();
        step();
        bus.in_valid = 1'b0;
        chk("ar_count3", queue_count, 3);
        chk("ar_halted", halted, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_count", queue_count, 0);
        chk("ar_halted0", halted, 0);
        chk("ar_valid", bus.out_valid, 0);
        chk("ar_ready", bus.in_ready, 1);
        chk("ar_local", bus.out_local_addr, 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("ar_rel_valid", bus.out_valid, 0);
        step();
        chk("ar_post_valid", bus.out_valid, 0);
        chk("ar_post_count", queue_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/instruction_dispatcher.md
INSTRUCTION_DISPATCHER -- requirements
Module: instruction_dispatcher

Interface
REQ-001 SHALL have parameter OPCODE_WIDTH, default 8, opcode field width (min 3).
REQ-002 SHALL have parameter FLAG_WIDTH, default 8, flag field width.
REQ-003 SHALL have parameter LENGTH_WIDTH, default 8, length field width.
REQ-004 SHALL have parameter HOST_MEMORY_ADDRESS_WIDTH, default 64, host address field width.
REQ-005 SHALL have parameter LOCAL_MEMORY_ADDRESS_WIDTH, default 24, local address field width.
REQ-006 SHALL have parameter QUEUE_DEPTH, default 4, instruction queue entries (power of two, >=2).
REQ-007 SHALL derive localparam INSTRUCTION_WIDTH as the sum of the five field widths (112 at defaults) and COUNT_WIDTH as $clog2(QUEUE_DEPTH+1).
REQ-008 SHALL have clk, input, 1, sole clock; all state updates on the rising edge.
REQ-009 SHALL have rst_n, input, 1, reset; asynchronous, active-low.
REQ-010 SHALL have in_valid input 1, in_ready output 1, in_instruction input INSTRUCTION_WIDTH, instruction push handshake; fields packed MSB-first as opcode, flags, length, host address, local address.
REQ-011 SHALL have out_valid output 4 (one-hot per unit: 0 MEM, 1 WEIGHT, 2 MXU, 3 ACT) and out_ready input 4.
REQ-012 SHALL have out_opcode, out_flags, out_length, out_host_addr, out_local_addr outputs at their field widths, holding the queue-head fields.
REQ-013 SHALL have unit_busy input 4, resume input 1, illegal_clear input 1, halted output 1, illegal_opcode output 1 (sticky), queue_count output COUNT_WIDTH.

Function
REQ-014 SHALL buffer accepted instructions in a QUEUE_DEPTH FIFO; push when in_valid && in_ready; in_ready = (queue_count != QUEUE_DEPTH), no push-when-full even on a simultaneous pop.
REQ-015 SHALL decode the head opcode: 0x00 NOP; 0x01 READ_HOST and 0x02 WRITE_HOST -> unit 0; 0x03 READ_WEIGHTS -> unit 1; 0x04 MATMUL -> unit 2; 0x05 ACTIVATE -> unit 3; 0x06 SYNC; 0x07 HALT; all other codes illegal.
REQ-016 SHALL implement FSM states RUN, SYNC_WAIT, HALTED; reset state RUN.
REQ-017 In RUN with a non-empty queue and dispatchable head, SHALL assert only out_valid[unit]; head SHALL pop on the edge where out_valid[u] && out_ready[u]; out_valid and fields stable until then.
REQ-018 Head NOP SHALL pop in one cycle with no out_valid; illegal head SHALL pop in one cycle, no out_valid, and set illegal_opcode.
REQ-019 Head SYNC SHALL pop in one cycle and enter SYNC_WAIT; SYNC_WAIT -> RUN on the first edge with unit_busy == 4'b0000; no dispatch in SYNC_WAIT.
REQ-020 Head HALT SHALL pop in one cycle and enter HALTED; halted = 1 in HALTED; HALTED -> RUN on an edge with resume = 1; pushes continue while not full; no dispatch.
REQ-021 resume outside HALTED SHALL be ignored.
REQ-022 illegal_opcode SHALL clear on illegal_clear; simultaneous set and clear SHALL leave it 1.
REQ-023 Minimum latency: instruction pushed on edge N SHALL be presented at the outputs from cycle N+1 when the queue was empty and state is RUN; no combinational in_valid -> out_valid path.
REQ-024 Write and read pointers SHALL wrap modulo QUEUE_DEPTH; queue_count SHALL reflect push/pop on the same edge (simultaneous push and pop: unchanged).
REQ-025 out_* field outputs SHALL be 0 when the queue is empty.

Reset
REQ-026 On rst_n = 0, SHALL immediately flush the queue, set state RUN, and drive out_valid = 0, halted = 0, illegal_opcode = 0, queue_count = 0, field outputs 0; in_ready = 1 while in reset and after.
REQ-027 Reset asserted mid-dispatch, SYNC_WAIT or HALTED SHALL discard all queued instructions; no out_valid pulse on reset release.

Verification
REQ-028 Push opcode 0x04, flags 0x01, length 0x10, local 0x000100 into empty queue, out_ready = 4'b0100 -> out_valid = 4'b0100 next cycle with those fields, popped on that edge, queue_count back to 0.
REQ-029 Push 5 instructions with out_ready = 0, QUEUE_DEPTH = 4 -> in_ready = 0 after 4th push, 5th held; queue_count = 4; release out_ready -> pops in order, pointers wrap, 5th accepted.
REQ-030 Queue SYNC then 0x01 with unit_busy = 4'b0010 for 3 cycles -> SYNC_WAIT, out_valid = 0 until unit_busy = 0, then out_valid = 4'b0001.
REQ-031 Queue HALT then 0x05 -> halted = 1, no dispatch; resume pulse -> halted = 0, out_valid = 4'b1000 next cycle.
REQ-032 Push opcode 0x2A then 0x03 -> illegal_opcode = 1, 0x2A dropped, out_valid = 4'b0010; illegal_opcode and illegal_clear in same cycle -> stays 1.
REQ-033 Assert rst_n = 0 with 3 queued instructions in HALTED -> queue_count = 0, halted = 0, out_valid = 0 with no clock edge.
